// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8-N-1 UART receiver with mid-bit sampling and framing-error detection
`timescale 1ns/1ps
module uart_rx #(
   parameter int CLKS_PER_BIT = 87
) (
   input  logic       i_Clock,
   input  logic       i_Rst_n,
   input  logic       i_Rx_Serial,
   output logic       o_Rx_DV,
   output logic [7:0] o_Rx_Byte,
   output logic       o_Rx_Frame_Err,
   output logic       o_Rx_Active
);

   localparam logic [7:0] HALF = 8'((CLKS_PER_BIT - 1) / 2);
   localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      CLEANUP
   } state_t;

   state_t     state;
   logic       sync1;
   logic       rx_s;
   logic [7:0] count;
   logic [2:0] bit_idx;
   logic [7:0] shift;

   always_ff @(posedge i_Clock) begin
      if (!i_Rst_n) begin
         sync1          <= 1'b1;
         rx_s           <= 1'b1;
         state          <= IDLE;
         count          <= 8'd0;
         bit_idx        <= 3'd0;
         shift          <= 8'd0;
         o_Rx_DV        <= 1'b0;
         o_Rx_Byte      <= 8'h00;
         o_Rx_Frame_Err <= 1'b0;
         o_Rx_Active    <= 1'b0;
      end else begin
         sync1          <= i_Rx_Serial;
         rx_s           <= sync1;
         o_Rx_DV        <= 1'b0;
         o_Rx_Frame_Err <= 1'b0;
         case (state)
            IDLE: begin
               count       <= 8'd0;
               bit_idx     <= 3'd0;
               o_Rx_Active <= 1'b0;
               if (!rx_s) begin
                  state       <= START;
                  o_Rx_Active <= 1'b1;
               end
            end
            // Confirm the start bit at its centre; a high line here was a glitch.
            START: begin
               if (count == HALF) begin
                  count <= 8'd0;
                  if (!rx_s) begin
                     state <= DATA;
                  end else begin
                     state       <= IDLE;
                     o_Rx_Active <= 1'b0;
                  end
               end else begin
                  count <= count + 8'd1;
               end
            end
            DATA: begin
               if (count == LAST) begin
                  count          <= 8'd0;
                  shift[bit_idx] <= rx_s;
                  if (bit_idx == 3'd7) begin
                     bit_idx <= 3'd0;
                     state   <= STOP;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                  end
               end else begin
                  count <= count + 8'd1;
               end
            end
            STOP: begin
               if (count == LAST) begin
                  count       <= 8'd0;
                  o_Rx_Active <= 1'b0;
                  state       <= CLEANUP;
                  if (rx_s) begin
                     o_Rx_Byte <= shift;
                     o_Rx_DV   <= 1'b1;
                  end else begin
                     o_Rx_Frame_Err <= 1'b1;
                  end
               end else begin
                  count <= count + 8'd1;
               end
            end
            // Hold off while the line is low so a break is never taken as a start bit.
            CLEANUP: begin
               if (rx_s) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx with randomized frames and reference queue
`timescale 1ns/1ps
module tb_uart_rx;
   localparam int  CPB    = 8;
   localparam real CLK_NS = 10.0;
   localparam real BIT_NS = CPB * CLK_NS;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx = 1'b1;
   logic       dv;
   logic [7:0] rx_byte;
   logic       ferr;
   logic       active;

   int n_checks = 0;
   int n_fail = 0;

   logic [7:0] got_q[$];
   logic [7:0] exp_q[$];
   int ferr_cnt = 0;
   int both_cnt = 0;
   int active_cyc = 0;

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .i_Clock(clk),
      .i_Rst_n(rst_n),
      .i_Rx_Serial(rx),
      .o_Rx_DV(dv),
      .o_Rx_Byte(rx_byte),
      .o_Rx_Frame_Err(ferr),
      .o_Rx_Active(active)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (dv) got_q.push_back(rx_byte);
      if (ferr) ferr_cnt++;
      if (dv && ferr) both_cnt++;
      if (active) active_cyc++;
   end

   task automatic clear_mon();
      got_q.delete();
      exp_q.delete();
      ferr_cnt = 0;
      both_cnt = 0;
      active_cyc = 0;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input real bit_ns);
      rx = 1'b0;
      #(bit_ns);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         #(bit_ns);
      end
      rx = stop_bit;
      #(bit_ns);
   endtask

   task automatic compare_queues(input string name);
      logic [7:0] g;
      n_checks++;
      if (got_q.size() !== exp_q.size()) begin
         n_fail++;
         $display("FAIL %s count: got %0d bytes, expected %0d", name, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         g = (i < got_q.size()) ? got_q[i] : 8'hxx;
         n_checks++;
         if (g !== exp_q[i]) begin
            n_fail++;
            $display("FAIL %s byte[%0d]: got %h, expected %h", name, i, g, exp_q[i]);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      rx = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      clear_mon();
      repeat (100) @(negedge clk);
      n_checks++;
      if (rx_byte !== 8'h00) begin n_fail++; $display("FAIL reset_byte: got %h, expected 00", rx_byte); end
      n_checks++;
      if (got_q.size() !== 0) begin n_fail++; $display("FAIL reset_dv: got %0d pulses, expected 0", got_q.size()); end
      n_checks++;
      if (ferr_cnt !== 0) begin n_fail++; $display("FAIL reset_ferr: got %0d pulses, expected 0", ferr_cnt); end
      n_checks++;
      if (active_cyc !== 0) begin n_fail++; $display("FAIL reset_active: got %0d active cycles, expected 0", active_cyc); end
   endtask

   task automatic test_single();
      clear_mon();
      exp_q.push_back(8'hA5);
      send_frame(8'hA5, 1'b1, BIT_NS);
      rx = 1'b1;
      #(2 * BIT_NS);
      compare_queues("single_a5");
      n_checks++;
      if (rx_byte !== 8'hA5) begin n_fail++; $display("FAIL single_hold: got %h, expected a5", rx_byte); end
      n_checks++;
      if (ferr_cnt !== 0) begin n_fail++; $display("FAIL single_ferr: got %0d, expected 0", ferr_cnt); end
      // Active spans mid-start through the stop sample: (CPB-1)/2 + 9*CPB + 1 cycles, +-2.
      n_checks++;
      if (active_cyc < 74 || active_cyc > 78) begin
         n_fail++;
         $display("FAIL single_active_len: got %0d cycles, expected 74..78", active_cyc);
      end
      n_checks++;
      if (active !== 1'b0) begin n_fail++; $display("FAIL single_active_end: got %b, expected 0", active); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] vals[$];
      clear_mon();
      vals = '{8'h00, 8'hFF, 8'h3C};
      for (int i = 0; i < 4; i++) vals.push_back(8'($urandom));
      foreach (vals[i]) begin
         exp_q.push_back(vals[i]);
         send_frame(vals[i], 1'b1, BIT_NS);
      end
      rx = 1'b1;
      #(2 * BIT_NS);
      compare_queues("back_to_back");
      n_checks++;
      if (ferr_cnt !== 0) begin n_fail++; $display("FAIL b2b_ferr: got %0d, expected 0", ferr_cnt); end
   endtask

   task automatic test_random();
      logic [7:0] b;
      clear_mon();
      for (int i = 0; i < 10; i++) begin
         b = 8'($urandom);
         exp_q.push_back(b);
         send_frame(b, 1'b1, BIT_NS);
         rx = 1'b1;
         #($urandom_range(0, 200) * 1.0);
      end
      #(2 * BIT_NS);
      compare_queues("random");
      n_checks++;
      if (ferr_cnt !== 0) begin n_fail++; $display("FAIL random_ferr: got %0d, expected 0", ferr_cnt); end
   endtask

   task automatic test_glitch();
      logic [7:0] prev;
      prev = rx_byte;
      clear_mon();
      @(negedge clk);
      rx = 1'b0;
      repeat (2) @(negedge clk);
      rx = 1'b1;
      #(3 * BIT_NS);
      n_checks++;
      if (got_q.size() !== 0) begin n_fail++; $display("FAIL glitch_dv: got %0d pulses, expected 0", got_q.size()); end
      n_checks++;
      if (ferr_cnt !== 0) begin n_fail++; $display("FAIL glitch_ferr: got %0d, expected 0", ferr_cnt); end
      n_checks++;
      if (rx_byte !== prev) begin n_fail++; $display("FAIL glitch_byte: got %h, expected %h", rx_byte, prev); end
      n_checks++;
      if (active_cyc > CPB) begin n_fail++; $display("FAIL glitch_active: got %0d cycles, expected <= %0d", active_cyc, CPB); end
   endtask

   task automatic test_frame_err();
      clear_mon();
      exp_q.push_back(8'h5A);
      send_frame(8'h5A, 1'b1, BIT_NS);
      rx = 1'b1;
      #(BIT_NS);
      send_frame(8'h12, 1'b0, BIT_NS);
      rx = 1'b0;
      #(3 * BIT_NS);
      rx = 1'b1;
      #(3 * BIT_NS);
      compare_queues("frame_err");
      n_checks++;
      if (ferr_cnt !== 1) begin n_fail++; $display("FAIL ferr_pulses: got %0d, expected 1", ferr_cnt); end
      n_checks++;
      if (rx_byte !== 8'h5A) begin n_fail++; $display("FAIL ferr_byte: got %h, expected 5a", rx_byte); end
      n_checks++;
      if (active !== 1'b0) begin n_fail++; $display("FAIL ferr_active: got %b, expected 0", active); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] b;
      b = 8'hC3;
      rx = 1'b0;
      #(BIT_NS);
      for (int i = 0; i < 4; i++) begin
         rx = b[i];
         #(BIT_NS);
      end
      rx = b[4];
      #(BIT_NS / 2);
      @(negedge clk);
      rst_n = 1'b0;
      rx = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if (rx_byte !== 8'h00) begin n_fail++; $display("FAIL midrst_byte: got %h, expected 00", rx_byte); end
      n_checks++;
      if (active !== 1'b0) begin n_fail++; $display("FAIL midrst_active: got %b, expected 0", active); end
      n_checks++;
      if (dv !== 1'b0 || ferr !== 1'b0) begin n_fail++; $display("FAIL midrst_pulses: got dv=%b ferr=%b, expected 0 0", dv, ferr); end
      @(negedge clk);
      rst_n = 1'b1;
      clear_mon();
      #(2 * BIT_NS);
      n_checks++;
      if (got_q.size() !== 0 || ferr_cnt !== 0) begin
         n_fail++;
         $display("FAIL midrst_discard: got dv=%0d ferr=%0d, expected 0 0", got_q.size(), ferr_cnt);
      end
      for (int k = 0; k < 3; k++) begin
         real bt;
         bt = (k == 0) ? BIT_NS : ((k == 1) ? BIT_NS / 1.03 : BIT_NS / 0.97);
         clear_mon();
         exp_q.push_back(b);
         send_frame(b, 1'b1, bt);
         rx = 1'b1;
         #(2 * BIT_NS);
         compare_queues(k == 0 ? "after_reset_c3" : (k == 1 ? "c3_fast" : "c3_slow"));
         n_checks++;
         if (ferr_cnt !== 0) begin n_fail++; $display("FAIL c3_ferr[%0d]: got %0d, expected 0", k, ferr_cnt); end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_random();
      test_glitch();
      test_frame_err();
      test_reset_mid();
      n_checks++;
      if (both_cnt !== 0) begin n_fail++; $display("FAIL dv_ferr_overlap: got %0d cycles, expected 0", both_cnt); end
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
